// File: rtl/spi_controller.sv
// spi_controller: SPI initiator for the two-byte {wr_rdn, addr} + data register frame, SPI modes 0-3.
// Define SPI_CTRL_CS_GAP_EN to add a GAP state that holds CS high for 2*CLK_DIV cycles after each frame.
module spi_controller #(
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 7,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              wr_rdn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic [REG_W-1:0]  rdata,
  output logic              busy,
  output logic              done,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = 2 * REG_W;
  localparam int EDGES   = 2 * FRAME_W;
  localparam int ECW     = $clog2(EDGES + 1);
  localparam int CW      = $clog2(2 * CLK_DIV + 1);

  localparam logic [CW-1:0]  HALF_TC   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  GAP_TC    = CW'(2 * CLK_DIV - 1);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(EDGES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef SPI_CTRL_CS_GAP_EN
    ,
    S_GAP   = 2'd2
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ECW-1:0]       edge_q, edge_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic [REG_W-1:0]     rx_q, rx_d;
  logic [REG_W-1:0]     rdata_q, rdata_d;
  logic                 mosi_q, mosi_d;
  logic                 sclk_q, sclk_d;
  logic                 done_q, done_d;
  logic                 cpha_q, cpha_d;
  logic                 wr_q, wr_d;

  logic                 accept;
  logic                 tick;
  logic                 last;
  logic                 sample_edge;
  logic [FRAME_W-1:0]   frame;

  // The done cycle is excluded so that a start coinciding with done is dropped.
  assign accept      = (state_q == S_IDLE) && start && ena && !done_q;
  assign tick        = (cnt_q == HALF_TC);
  assign last        = (edge_q == LAST_EDGE);
  // edge_q counts edges already made, so the upcoming edge is leading when edge_q is even.
  assign sample_edge = ~edge_q[0] ^ cpha_q;
  assign frame       = {wr_rdn, addr, wdata};

  // NOTE: every flop, including the shift registers, is reset so an aborted frame leaves no stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      cpha_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      cpha_q  <= cpha_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: begin
        if (tick && last) begin
`ifdef SPI_CTRL_CS_GAP_EN
          state_d = S_GAP;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef SPI_CTRL_CS_GAP_EN
      S_GAP:   if (cnt_q == GAP_TC) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    cpha_d  = cpha_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cpha_d = mode[0];
          wr_d   = wr_rdn;
          sclk_d = mode[1];
          cnt_d  = '0;
          edge_d = '0;
          // CPHA=0 presents bit 15 with CS; CPHA=1 waits for the first leading edge.
          if (mode[0]) begin
            sr_d   = frame;
            mosi_d = 1'b0;
          end else begin
            sr_d   = {frame[FRAME_W-2:0], 1'b0};
            mosi_d = frame[FRAME_W-1];
          end
        end
      end
      S_SHIFT: begin
        if (tick) begin
          cnt_d = '0;
          if (last) begin
            done_d = 1'b1;
            if (!wr_q) rdata_d = rx_q;
          end else begin
            edge_d = edge_q + ECW'(1);
            sclk_d = ~sclk_q;
            if (sample_edge) begin
              rx_d = {rx_q[REG_W-2:0], spi_miso};
            end else begin
              mosi_d = sr_q[FRAME_W-1];
              sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef SPI_CTRL_CS_GAP_EN
      S_GAP:   cnt_d = cnt_q + CW'(1);
`endif
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    spi_cs_n = (state_q != S_SHIFT);
    done     = done_q;
    spi_clk  = sclk_q;
    spi_mosi = mosi_q;
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed table plus random frames against a bit-level SPI target model for spi_controller.
module tb_spi_controller;

  localparam int REG_W  = 8;
  localparam int ADDR_W = 7;
`ifdef SPI_CTRL_CS_GAP_EN
  localparam int CLK_DIV = 3;
  localparam bit GAP_EN  = 1'b1;
`else
  localparam int CLK_DIV = 2;
  localparam bit GAP_EN  = 1'b0;
`endif
  localparam int FRAME_CYC = 33 * CLK_DIV;
  localparam int TAIL      = 2 * CLK_DIV + 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [1:0]        mode;
  logic              start;
  logic              wr_rdn;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0]  wdata;
  logic [REG_W-1:0]  rdata;
  logic              busy;
  logic              done;
  logic              spi_cs_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;

  spi_controller #(.REG_W(REG_W), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .start(start), .wr_rdn(wr_rdn),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] miso_word;
    int          disturb;   // 0 none, 1 start+input changes mid-frame, 2 ena dropped mid-frame
    logic [15:0] exp_mosi;
    logic [15:0] mosi_mask;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[7];

  logic [15:0] r_mosi;
  logic [7:0]  r_rd_at_done;
  int          r_cs_low, r_cs_low_after, r_done_cyc, r_done_cnt, r_edges, r_min_stable;
  logic        r_clk_c1, r_clk_at_done, r_busy_at_done;
  logic [7:0]  model_rdata;

  // Target side of the link: observes the bus once per cycle, records MOSI at the sampling
  // edges and shifts its own word out on MISO at the opposite edges.
  task automatic run_frame(input vec_t v);
    int   edges, last_mosi_cyc, idx;
    logic prev_cs, prev_clk, prev_mosi;
    bit   cpha, leading, sampling;
    cpha = v.mode[0];
    @(negedge clk);
    mode = v.mode; wr_rdn = v.wr; addr = v.addr; wdata = v.wdata; start = 1'b1;
    prev_cs = spi_cs_n; prev_clk = spi_clk; prev_mosi = spi_mosi;
    r_mosi = '0; r_rd_at_done = 'x; r_cs_low = 0; r_cs_low_after = 0; r_done_cyc = -1;
    r_done_cnt = 0; r_min_stable = 1000; r_clk_c1 = 1'bx; r_clk_at_done = 1'bx; r_busy_at_done = 1'bx;
    edges = 0; last_mosi_cyc = 0;
    for (int cyc = 1; cyc <= FRAME_CYC + 1 + TAIL; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.disturb == 1 && cyc == 10) begin
        start = 1'b1; mode = ~v.mode; addr = ~v.addr; wdata = ~v.wdata; wr_rdn = ~v.wr;
      end
      if (v.disturb == 2 && cyc == 10) ena = 1'b0;
      if (cyc == 1) r_clk_c1 = spi_clk;
      if (spi_mosi !== prev_mosi) last_mosi_cyc = cyc;
      if (!spi_cs_n && prev_cs && !cpha) spi_miso = v.miso_word[15];
      if (!spi_cs_n && !prev_cs && spi_clk !== prev_clk) begin
        edges++;
        leading  = (edges % 2) == 1;
        sampling = cpha ? !leading : leading;
        if (sampling) begin
          r_mosi = {r_mosi[14:0], spi_mosi};
          if (cyc - last_mosi_cyc < r_min_stable) r_min_stable = cyc - last_mosi_cyc;
        end else begin
          idx = cpha ? (edges - 1) / 2 : edges / 2;
          if (idx <= 15) spi_miso = v.miso_word[15 - idx];
        end
      end
      if (done) begin
        r_done_cnt++; r_done_cyc = cyc; r_rd_at_done = rdata;
        r_clk_at_done = spi_clk; r_busy_at_done = busy;
      end
      if (!spi_cs_n) begin
        if (r_done_cnt == 0) r_cs_low++;
        else r_cs_low_after++;
      end
      prev_cs = spi_cs_n; prev_clk = spi_clk; prev_mosi = spi_mosi;
    end
    ena = 1'b1;
    r_edges = edges;
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    check({tag, " mosi"}, 32'(r_mosi & v.mosi_mask), 32'(v.exp_mosi & v.mosi_mask));
    check({tag, " rdata"}, 32'(r_rd_at_done), 32'(v.exp_rdata));
    check({tag, " cs_low"}, r_cs_low, FRAME_CYC);
    check({tag, " done_cycle"}, r_done_cyc, FRAME_CYC + 1);
    check({tag, " done_pulses"}, r_done_cnt, 1);
    check({tag, " edges"}, r_edges, 32);
    check({tag, " sclk_cyc1"}, 32'(r_clk_c1), 32'(v.mode[1]));
    check({tag, " sclk_idle"}, 32'(r_clk_at_done), 32'(v.mode[1]));
    check({tag, " busy_at_done"}, 32'(r_busy_at_done), 32'(GAP_EN));
    check({tag, " mosi_setup"}, 32'(r_min_stable >= CLK_DIV), 32'd1);
    check({tag, " no_extra_frame"}, r_cs_low_after, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cs_high, busy_low, seen_low, seen_busy, seen_done;
    bit   fell, got_done;

    rst = 1'b1; ena = 1'b1; mode = 2'b00; start = 1'b0; wr_rdn = 1'b0;
    addr = '0; wdata = '0; spi_miso = 1'b0;
    model_rdata = 8'h00;

    //            mode   wr    addr   wdata  miso      dist exp_mosi  mask      rdata
    vecs[0] = '{2'd0, 1'b1, 7'h05, 8'hA5, 16'h1234, 0, 16'h85A5, 16'hFFFF, 8'h00};
    vecs[1] = '{2'd3, 1'b0, 7'h0A, 8'h5F, 16'h963C, 0, 16'h0A00, 16'hFF00, 8'h3C};
    vecs[2] = '{2'd1, 1'b0, 7'h11, 8'h00, 16'h5AC3, 0, 16'h1100, 16'hFF00, 8'hC3};
    vecs[3] = '{2'd2, 1'b0, 7'h2B, 8'hFF, 16'hA5C3, 0, 16'h2B00, 16'hFF00, 8'hC3};
    vecs[4] = '{2'd0, 1'b1, 7'h7F, 8'h00, 16'hFFFF, 1, 16'hFF00, 16'hFFFF, 8'hC3};
    vecs[5] = '{2'd1, 1'b1, 7'h40, 8'h81, 16'h0F0F, 2, 16'hC081, 16'hFFFF, 8'hC3};
    vecs[6] = '{2'd2, 1'b0, 7'h00, 8'h77, 16'h0001, 0, 16'h0000, 16'hFF00, 8'h01};

    repeat (2) @(negedge clk);
    check("reset cs_n", 32'(spi_cs_n), 32'd1);
    check("reset spi_clk", 32'(spi_clk), 32'd0);
    check("reset mosi", 32'(spi_mosi), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
      check_frame(vecs[i], $sformatf("vec%0d", i));
      model_rdata = vecs[i].exp_rdata;
    end

    // start with ena low must not open a frame
    @(negedge clk);
    ena = 1'b0; start = 1'b1;
    seen_low = 0; seen_busy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!spi_cs_n) seen_low++;
      if (busy) seen_busy++;
    end
    ena = 1'b1;
    check("ena0 cs_low_cycles", seen_low, 0);
    check("ena0 busy_cycles", seen_busy, 0);

    // back-to-back: start held from the done cycle onward
    @(negedge clk);
    mode = 2'd0; wr_rdn = 1'b1; addr = 7'h33; wdata = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < FRAME_CYC + 10 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("b2b first_done", 32'(got_done), 32'd1);
    start = 1'b1;
    cs_high = 1; busy_low = busy ? 0 : 1;
    fell = 1'b0;
    for (int c = 0; c < 4 * CLK_DIV + 10 && !fell; c++) begin
      @(negedge clk);
      if (!spi_cs_n) fell = 1'b1;
      else begin
        cs_high++;
        if (!busy) busy_low++;
      end
    end
    start = 1'b0;
    check("b2b second_accepted", 32'(fell), 32'd1);
`ifdef SPI_CTRL_CS_GAP_EN
    check("b2b cs_high_min", 32'(cs_high >= 2 * CLK_DIV + 1), 32'd1);
    check("b2b busy_through_gap", busy_low, 0);
`else
    check("b2b cs_high", cs_high, 2);
    check("b2b busy_low", busy_low, 2);
`endif
    got_done = 1'b0;
    for (int c = 0; c < FRAME_CYC + 10 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("b2b second_done", 32'(got_done), 32'd1);
    repeat (TAIL) @(negedge clk);

    // asynchronous reset at edge 10 of a write
    @(negedge clk);
    mode = 2'd0; wr_rdn = 1'b1; addr = 7'h12; wdata = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10 * CLK_DIV) @(negedge clk);
    check("rst pre cs_n", 32'(spi_cs_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst async cs_n", 32'(spi_cs_n), 32'd1);
    check("rst async spi_clk", 32'(spi_clk), 32'd0);
    check("rst async busy", 32'(busy), 32'd0);
    seen_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst = 1'b0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("rst no_done", seen_done, 0);
    model_rdata = 8'h00;
    check("rst rdata", 32'(rdata), 32'(model_rdata));
    run_frame(vecs[0]);
    check_frame(vecs[0], "post_rst");

    // random frames against the reference model
    for (int i = 0; i < 16; i++) begin
      v.mode      = 2'($urandom_range(0, 3));
      v.wr        = 1'($urandom_range(0, 1));
      v.addr      = 7'($urandom);
      v.wdata     = 8'($urandom);
      v.miso_word = 16'($urandom);
      v.disturb   = 0;
      v.exp_mosi  = {v.wr, v.addr, v.wdata};
      v.mosi_mask = v.wr ? 16'hFFFF : 16'hFF00;
      v.exp_rdata = v.wr ? model_rdata : v.miso_word[7:0];
      run_frame(v);
      check_frame(v, $sformatf("rnd%0d", i));
      model_rdata = v.exp_rdata;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
